// File: rtl/car_sensor_pkg.sv
// Shared types and helpers for the car sensor-bus ranging blocks.
package car_sensor_pkg;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_e;

  // Widths and timeout results saturate to all ones; users truncate to their width.
  localparam logic [31:0] WIDTH_SAT = 32'hFFFF_FFFF;
  localparam int          MAX_CH    = 16;

  // First set mask bit strictly after `last`, wrapping at n_ch; returns `last` if the mask is empty.
  function automatic logic [3:0] next_chan(input logic [MAX_CH-1:0] mask,
                                           input logic [3:0]        last,
                                           input int                n_ch);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = (int'(last) + i) % n_ch;
      if (!found && i <= n_ch && mask[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ultrasound_echo_sync.sv
// Two-flop synchroniser for the raw echo lines plus registered rise/fall pulses.
module ultrasound_echo_sync #(
  parameter int N_CH = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] echo_i,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
);

  logic [N_CH-1:0] s1_q, s2_q, s3_q, rise_q, fall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      s1_q   <= echo_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ultrasound_array_ranger.sv
// N-channel ultrasonic ranger: masked round-robin firing, echo width in us,
// timeout detection, result strobe and a per-channel latest-result register file.
module ultrasound_array_ranger
  import car_sensor_pkg::*;
#(
  parameter int N_CH       = 6,
  parameter int CNT_W      = 16,
  parameter int CLK_PER_US = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 10000,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N_CH-1:0]  chan_mask,
  input  logic [N_CH-1:0]  feedback_in,
  output logic [N_CH-1:0]  trigger_out,
  output logic             res_valid,
  output logic [CH_W-1:0]  res_chan,
  output logic [CNT_W-1:0] res_width,
  output logic             res_timeout,
  input  logic [CH_W-1:0]  rd_addr,
  output logic [CNT_W:0]   rd_data
);

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] SAT       = CNT_W'(WIDTH_SAT);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_US - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

  state_e                     state_q;
  logic [PRE_W-1:0]           pre_q;
  logic [CNT_W-1:0]           cnt_q, cnt_inc;
  logic [CH_W-1:0]            cur_q, res_chan_q;
  logic [N_CH-1:0]            trig_q, cur_oh, rise_s, fall_s;
  logic                       res_valid_q, res_to_q, tick;
  logic [CNT_W-1:0]           res_width_q;
  logic [N_CH-1:0][CNT_W:0]   regs_q;
  logic [CNT_W:0]             rd_q;

  ultrasound_echo_sync #(.N_CH(N_CH)) u_sync (
    .clk_i  (CLOCK_50),
    .rst_ni (reset_n),
    .echo_i (feedback_in),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  assign tick    = (pre_q == PRE_MAX);
  assign cnt_inc = (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
  assign cur_oh  = N_CH'(1) << cur_q;

  // Every state change also restarts the prescaler and the us counter.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      cur_q       <= LAST_CH;
      trig_q      <= '0;
      res_valid_q <= 1'b0;
      res_chan_q  <= '0;
      res_width_q <= '0;
      res_to_q    <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      trig_q      <= (state_q == TRIG) ? cur_oh : '0;
      pre_q       <= tick ? '0 : pre_q + 1'b1;
      if (tick) cnt_q <= cnt_inc;
      unique case (state_q)
        IDLE: if (enable && chan_mask != '0) begin
          cur_q   <= CH_W'(next_chan(MAX_CH'(chan_mask), 4'(cur_q), N_CH));
          state_q <= TRIG;
          pre_q   <= '0;
          cnt_q   <= '0;
        end
        TRIG: if (tick && cnt_q == TRIG_LAST) begin
          state_q <= WAIT_RISE;
          pre_q   <= '0;
          cnt_q   <= '0;
        end
        WAIT_RISE: if (rise_s[cur_q]) begin
          state_q <= MEASURE;
          pre_q   <= '0;
          cnt_q   <= '0;
        end else if (tick && cnt_q == TO_LAST) begin
          res_valid_q <= 1'b1;
          res_chan_q  <= cur_q;
          res_width_q <= SAT;
          res_to_q    <= 1'b1;
          state_q     <= GAP;
          pre_q       <= '0;
          cnt_q       <= '0;
        end
        MEASURE: if (fall_s[cur_q]) begin
          // A tick landing on the falling-edge cycle still belongs to the echo.
          res_valid_q <= 1'b1;
          res_chan_q  <= cur_q;
          res_width_q <= tick ? cnt_inc : cnt_q;
          res_to_q    <= 1'b0;
          state_q     <= GAP;
          pre_q       <= '0;
          cnt_q       <= '0;
        end else if (tick && cnt_q == TO_LAST) begin
          res_valid_q <= 1'b1;
          res_chan_q  <= cur_q;
          res_width_q <= SAT;
          res_to_q    <= 1'b1;
          state_q     <= GAP;
          pre_q       <= '0;
          cnt_q       <= '0;
        end
        GAP: if (tick && cnt_q == GAP_LAST) begin
          state_q <= IDLE;
          pre_q   <= '0;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read port samples before the write lands, so a same-cycle read returns the old value.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      regs_q <= '0;
      rd_q   <= '0;
    end else begin
      if (res_valid_q) regs_q[res_chan_q] <= {res_to_q, res_width_q};
      rd_q <= (int'(rd_addr) < N_CH) ? regs_q[rd_addr] : '0;
    end
  end

  assign trigger_out = trig_q;
  assign res_valid   = res_valid_q;
  assign res_chan    = res_chan_q;
  assign res_width   = res_width_q;
  assign res_timeout = res_to_q;
  assign rd_data     = rd_q;

endmodule

// File: tb/tb_ultrasound_array_ranger.sv
// Bench for ultrasound_array_ranger: reactive echo responder plus spec-level expectations.
module tb_ultrasound_array_ranger;

  localparam int NC = 3;

  logic        clk;
  logic        reset_n, enable;
  logic [2:0]  chan_mask, feedback_in, trigger_out;
  logic        res_valid, res_timeout;
  logic [1:0]  res_chan, rd_addr;
  logic [15:0] res_width;
  logic [16:0] rd_data;

  ultrasound_array_ranger #(
    .N_CH(3), .CNT_W(16), .CLK_PER_US(5), .TRIG_US(2), .TIMEOUT_US(100), .GAP_US(3)
  ) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .chan_mask(chan_mask),
    .feedback_in(feedback_in), .trigger_out(trigger_out), .res_valid(res_valid),
    .res_chan(res_chan), .res_width(res_width), .res_timeout(res_timeout),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; int cyc; int w; bit to; } res_t;
  typedef struct { int ch; int start; int len; } trg_t;

  res_t res_q[$];
  trg_t trg_q[$];
  int   trig_starts, onehot_bad;
  int   t_start[NC], fall_cyc[NC];
  int   dly[NC], len[NC];
  bit   pre_high[NC];
  int   total = 0, bad = 0;

  // Echo responder + event recorder. A channel's echo rises dly cycles after its
  // trigger falls (never if dly<0) and stays high for len cycles.
  initial begin : responder
    logic [2:0] prev, fb;
    int cd_rise[NC], cd_fall[NC];
    res_t r;
    trg_t t;
    prev = '0; fb = '0; feedback_in = '0;
    for (int c = 0; c < NC; c++) begin cd_rise[c] = 0; cd_fall[c] = 0; end
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = '0; fb = '0;
        res_q.delete(); trg_q.delete();
        trig_starts = 0; onehot_bad = 0;
        for (int c = 0; c < NC; c++) begin cd_rise[c] = 0; cd_fall[c] = 0; fall_cyc[c] = -1; end
      end else begin
        if (res_valid) begin
          r.ch = int'(res_chan); r.cyc = cyc; r.w = int'(res_width); r.to = res_timeout;
          res_q.push_back(r);
        end
        if ($countones(trigger_out) > 1) onehot_bad++;
        for (int c = 0; c < NC; c++) begin
          if (trigger_out[c] && !prev[c]) begin
            t_start[c] = cyc; trig_starts++;
            if (pre_high[c]) fb[c] = 1'b1;
          end
          if (!trigger_out[c] && prev[c]) begin
            t.ch = c; t.start = t_start[c]; t.len = cyc - t_start[c];
            trg_q.push_back(t);
            if (pre_high[c]) fb[c] = 1'b0;
            if (dly[c] >= 0) cd_rise[c] = dly[c] + 1;
          end
          if (cd_fall[c] > 0) begin
            cd_fall[c]--;
            if (cd_fall[c] == 0) begin fb[c] = 1'b0; fall_cyc[c] = cyc; end
          end
          if (cd_rise[c] > 0) begin
            cd_rise[c]--;
            if (cd_rise[c] == 0) begin fb[c] = 1'b1; cd_fall[c] = len[c]; end
          end
        end
        prev = trigger_out;
      end
      feedback_in = fb;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Spec rule: next set mask bit strictly after the last served channel, wrapping.
  function automatic int next_ch(input int mask, input int last);
    for (int i = 1; i <= NC; i++) if (mask[(last + i) % NC]) return (last + i) % NC;
    return -1;
  endfunction

  task automatic set_echo(input int c, input int d, input int l, input bit ph);
    dly[c] = d; len[c] = l; pre_high[c] = ph;
  endtask

  task automatic apply_reset(input logic [2:0] mask);
    reset_n = 1'b0; enable = 1'b0; chan_mask = mask;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_res(input int n, input int budget);
    int w = 0;
    while (res_q.size() < n && w < budget) begin @(negedge clk); w++; end
  endtask

  task automatic wait_trg(input int n, input int budget);
    int w = 0;
    while (trg_q.size() < n && w < budget) begin @(negedge clk); w++; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; chan_mask = '0; rd_addr = '0;
    for (int c = 0; c < NC; c++) set_echo(c, -1, 1, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (trigger_out !== 3'b000) begin bad++; $display("FAIL reset_trig: got %b want 000", trigger_out); end
    total++; if ({res_valid, res_timeout} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {res_valid, res_timeout}); end
    total++; if (res_chan !== 2'd0 || res_width !== 16'd0) begin bad++; $display("FAIL reset_res: chan %0d width %0d want 0 0", res_chan, res_width); end
    reset_n = 1'b1;
    for (int a = 0; a < NC; a++) begin
      rd_addr = 2'(a);
      repeat (2) @(negedge clk);
      total++; if (rd_data !== 17'd0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0", a, rd_data); end
    end
  endtask

  task automatic test_round_robin;
    int last, ch;
    for (int c = 0; c < NC; c++) set_echo(c, 25, 200, 1'b0);
    apply_reset(3'b111); enable = 1'b1;
    wait_trg(4, 4000);
    total++;
    if (trg_q.size() < 4 || res_q.size() < 3) begin
      bad++; $display("FAIL rr_count: got %0d trig %0d res want 4 3", trg_q.size(), res_q.size());
    end else begin
      last = NC - 1;
      for (int k = 0; k < 4; k++) begin
        ch = next_ch(7, last); last = ch;
        total++; if (trg_q[k].ch !== ch) begin bad++; $display("FAIL rr_trig_ch%0d: got %0d want %0d", k, trg_q[k].ch, ch); end
        total++; if (trg_q[k].len !== 10) begin bad++; $display("FAIL rr_trig_len%0d: got %0d want 10", k, trg_q[k].len); end
      end
      for (int k = 0; k < 3; k++) begin
        total++; if (res_q[k].ch !== k || res_q[k].w !== 40 || res_q[k].to !== 1'b0) begin
          bad++; $display("FAIL rr_res%0d: got ch %0d w %0d to %0d want %0d 40 0", k, res_q[k].ch, res_q[k].w, res_q[k].to, k);
        end
        total++; if (res_q[k].cyc !== fall_cyc[k] + 4) begin bad++; $display("FAIL rr_res_lat%0d: got %0d want %0d", k, res_q[k].cyc, fall_cyc[k] + 4); end
        total++; if (trg_q[k+1].start - res_q[k].cyc !== 17) begin bad++; $display("FAIL rr_gap%0d: got %0d want 17", k, trg_q[k+1].start - res_q[k].cyc); end
      end
    end
    total++; if (onehot_bad !== 0) begin bad++; $display("FAIL rr_onehot: got %0d want 0", onehot_bad); end
    enable = 1'b0;
  endtask

  task automatic test_timeout;
    set_echo(0, 25, 200, 1'b0); set_echo(1, -1, 1, 1'b0); set_echo(2, 25, 200, 1'b0);
    apply_reset(3'b111); enable = 1'b1; rd_addr = 2'd1;
    wait_res(2, 3000);
    total++;
    if (res_q.size() < 2 || trg_q.size() < 2) begin
      bad++; $display("FAIL to_count: got %0d res want 2", res_q.size());
    end else begin
      total++; if (res_q[1].ch !== 1 || res_q[1].to !== 1'b1 || res_q[1].w !== 16'hFFFF) begin
        bad++; $display("FAIL to_res: got ch %0d to %0d w %h want 1 1 ffff", res_q[1].ch, res_q[1].to, res_q[1].w);
      end
      total++; if (res_q[1].cyc - (trg_q[1].start + 9) !== 500) begin
        bad++; $display("FAIL to_lat: got %0d want 500", res_q[1].cyc - (trg_q[1].start + 9));
      end
    end
    repeat (2) @(negedge clk);
    total++; if (rd_data !== 17'h1FFFF) begin bad++; $display("FAIL to_reg1: got %h want 1ffff", rd_data); end
    enable = 1'b0;
  endtask

  task automatic test_mask;
    int last, ch, ch1_seen;
    for (int c = 0; c < NC; c++) set_echo(c, 5, 20, 1'b0);
    apply_reset(3'b101); enable = 1'b1;
    wait_trg(4, 3000);
    total++;
    if (trg_q.size() < 4) begin
      bad++; $display("FAIL mask_count: got %0d want 4", trg_q.size());
    end else begin
      last = NC - 1; ch1_seen = 0;
      for (int k = 0; k < 4; k++) begin
        ch = next_ch(5, last); last = ch;
        if (trg_q[k].ch == 1) ch1_seen++;
        total++; if (trg_q[k].ch !== ch) begin bad++; $display("FAIL mask_ch%0d: got %0d want %0d", k, trg_q[k].ch, ch); end
      end
      total++; if (ch1_seen !== 0) begin bad++; $display("FAIL mask_ch1: got %0d want 0", ch1_seen); end
    end
    apply_reset(3'b000); enable = 1'b1;
    repeat (300) @(negedge clk);
    total++; if (trig_starts !== 0 || res_q.size() !== 0) begin
      bad++; $display("FAIL mask_zero: got %0d trig %0d res want 0 0", trig_starts, res_q.size());
    end
    enable = 1'b0;
  endtask

  task automatic test_early_high;
    set_echo(0, 10, 35, 1'b1); set_echo(1, -1, 1, 1'b0); set_echo(2, -1, 1, 1'b0);
    apply_reset(3'b001); enable = 1'b1;
    wait_res(1, 1000);
    total++;
    if (res_q.size() < 1) begin
      bad++; $display("FAIL early_count: got 0 want 1");
    end else begin
      total++; if (res_q[0].ch !== 0 || res_q[0].w !== 7 || res_q[0].to !== 1'b0) begin
        bad++; $display("FAIL early_res: got ch %0d w %0d to %0d want 0 7 0", res_q[0].ch, res_q[0].w, res_q[0].to);
      end
    end
    enable = 1'b0;
    pre_high[0] = 1'b0;
  endtask

  task automatic test_reset_mid;
    int w;
    for (int c = 0; c < NC; c++) set_echo(c, 5, 20, 1'b0);
    apply_reset(3'b111); enable = 1'b1; rd_addr = 2'd0;
    wait_res(1, 1000);
    w = 0;
    while (!trigger_out[1] && w < 500) begin @(negedge clk); w++; end
    total++; if (trigger_out[1] !== 1'b1) begin bad++; $display("FAIL rmid_trig1: got %b want x1x", trigger_out); end
    repeat (3) @(negedge clk);
    total++; if (rd_data !== 17'd4) begin bad++; $display("FAIL rmid_pre_reg0: got %h want 4", rd_data); end
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (trigger_out !== 3'b000) begin bad++; $display("FAIL rmid_trig: got %b want 000", trigger_out); end
    total++; if ({res_valid, res_timeout, res_chan, res_width} !== 20'd0) begin
      bad++; $display("FAIL rmid_res: got %h want 0", {res_valid, res_timeout, res_chan, res_width});
    end
    total++; if (rd_data !== 17'd0) begin bad++; $display("FAIL rmid_rd: got %h want 0", rd_data); end
    reset_n = 1'b1;
    @(negedge clk);
    wait_trg(1, 200);
    total++; if (trg_q.size() < 1 || trg_q[0].ch !== 0) begin
      bad++; $display("FAIL rmid_first: got %0d trig want ch 0", trg_q.size());
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop;
    int w, s0;
    set_echo(0, 5, 50, 1'b0); set_echo(1, 5, 300, 1'b0); set_echo(2, 5, 50, 1'b0);
    apply_reset(3'b111); enable = 1'b1; rd_addr = 2'd1;
    wait_res(2, 2000);
    len[1] = 155;
    wait_res(4, 2000);
    w = 0;
    while (!feedback_in[1] && w < 500) begin @(negedge clk); w++; end
    repeat (10) @(negedge clk);
    enable = 1'b0;
    w = 0;
    while (!(res_valid && res_chan == 2'd1) && w < 1000) begin @(negedge clk); w++; end
    total++; if (res_valid !== 1'b1 || res_width !== 16'd31 || res_timeout !== 1'b0) begin
      bad++; $display("FAIL drop_res: got v %0d w %0d to %0d want 1 31 0", res_valid, res_width, res_timeout);
    end
    @(negedge clk);
    total++; if (rd_data !== 17'd60) begin bad++; $display("FAIL drop_rd_old: got %0d want 60", rd_data); end
    @(negedge clk);
    total++; if (rd_data !== 17'd31) begin bad++; $display("FAIL drop_rd_new: got %0d want 31", rd_data); end
    s0 = trig_starts;
    repeat (120) @(negedge clk);
    total++; if (trig_starts !== s0 || trigger_out !== 3'b000) begin
      bad++; $display("FAIL drop_idle: got %0d new triggers want 0", trig_starts - s0);
    end
    total++; if (res_q.size() !== 5) begin bad++; $display("FAIL drop_res_count: got %0d want 5", res_q.size()); end
  endtask

  task automatic test_random;
    int mask, last, ch, ew;
    bit eto;
    for (int run = 0; run < 3; run++) begin
      mask = $urandom_range(1, 7);
      for (int c = 0; c < NC; c++)
        set_echo(c, ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 40)),
                 int'($urandom_range(1, 450)), 1'b0);
      apply_reset(3'(mask)); enable = 1'b1;
      wait_res(5, 5000);
      total++;
      if (res_q.size() < 5) begin
        bad++; $display("FAIL rand%0d_count: got %0d want 5", run, res_q.size());
      end else begin
        last = NC - 1;
        for (int k = 0; k < 5; k++) begin
          ch = next_ch(mask, last); last = ch;
          eto = (dly[ch] < 0);
          ew  = eto ? 16'hFFFF : len[ch] / 5;
          total++; if (res_q[k].ch !== ch || res_q[k].w !== ew || res_q[k].to !== eto) begin
            bad++; $display("FAIL rand%0d_res%0d: got ch %0d w %0d to %0d want %0d %0d %0d",
                            run, k, res_q[k].ch, res_q[k].w, res_q[k].to, ch, ew, eto);
          end
        end
      end
      total++; if (onehot_bad !== 0) begin bad++; $display("FAIL rand%0d_onehot: got %0d want 0", run, onehot_bad); end
      enable = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_mask();
    test_early_high();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
